// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// A zero divisor skips the iterations and returns all-ones with the dividend as remainder.
module seq_divider #(
    parameter int unsigned MBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MBITS-1:0] dividend,
    input  logic [MBITS-1:0] divisor,
    output logic [MBITS-1:0] quotient,
    output logic [MBITS-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(MBITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [MBITS-1:0] d;
    logic [MBITS-1:0] q;
    logic [MBITS-1:0] r;
    logic [CW-1:0]    count;

    logic [MBITS:0]   rs;
    logic [MBITS:0]   trial;
    logic [MBITS-1:0] q_nxt;
    logic [MBITS-1:0] r_nxt;

    // {1'b1,~d}+1 is -d at MBITS+1 bits, so trial[MBITS] set means rs < d (borrow).
    assign rs    = {r, q[MBITS-1]};
    assign trial = rs + {1'b1, ~d} + (MBITS + 1)'(1);
    assign q_nxt = {q[MBITS-2:0], ~trial[MBITS]};
    assign r_nxt = trial[MBITS] ? rs[MBITS-1:0] : trial[MBITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            d           <= '0;
            q           <= '0;
            r           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        d <= divisor;
                        q <= dividend;
                        r <= '0;
                        if (divisor != '0) begin
                            count       <= CW'(MBITS);
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end else begin
                            count       <= '0;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    q     <= q_nxt;
                    r     <= r_nxt;
                    count <= count - CW'(1);
                    // Last iteration: publish results straight from the step logic.
                    if (count == CW'(1)) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised scoreboard bench for seq_divider: the driver queues expected results from
// plain integer division, and a negedge monitor checks every done pulse against them.
module tb_seq_divider;

    localparam int unsigned MBITS = 16;

    typedef struct packed {
        logic [MBITS-1:0] q;
        logic [MBITS-1:0] r;
        logic             dz;
        int unsigned      acc;
        int unsigned      lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [MBITS-1:0] dividend;
    logic [MBITS-1:0] divisor;
    logic [MBITS-1:0] quotient;
    logic [MBITS-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int unsigned cyc;
    int unsigned total;
    int unsigned bad;
    exp_t        sb[$];
    exp_t        mon_e;

    seq_divider #(.MBITS(MBITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: plain integer division; latency counted in edges after the accepting edge.
    function automatic exp_t model(input logic [MBITS-1:0] a, input logic [MBITS-1:0] b,
                                   input int unsigned acc);
        exp_t e;
        int unsigned ai;
        int unsigned bi;
        ai    = int'(a);
        bi    = int'(b);
        e.acc = acc;
        if (bi == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = MBITS'(ai / bi);
            e.r   = MBITS'(ai % bi);
            e.dz  = 1'b0;
            e.lat = MBITS + 1;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending operation (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(mon_e.q));
                chk("remainder", 32'(remainder), 32'(mon_e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
                chk("latency", cyc + 1 - mon_e.acc, mon_e.lat);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_done(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done after %0d cycles want done", budget);
            sb.delete();
        end
    endtask

    // Called at negedge+1; start is sampled on the following posedge.
    task automatic issue(input logic [MBITS-1:0] a, input logic [MBITS-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        #1;
        start = 1'b0;
        if (b != '0) chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_op(input logic [MBITS-1:0] a, input logic [MBITS-1:0] b,
                          input int unsigned gap);
        repeat (gap) begin
            @(negedge clk);
            #1;
        end
        issue(a, b);
        wait_done(3 * MBITS + 10);
    endtask

    initial begin
        logic [MBITS-1:0] a;
        logic [MBITS-1:0] b;
        int unsigned      sel;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        run_op(16'd100, 16'd7, 1);
        run_op(16'hFFFF, 16'h0001, 1);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(16'd5, 16'd0, 1);
        run_op(16'd9, 16'd3, 0);
        run_op(16'd3, 16'd10, 2);
        run_op(16'd0, 16'd9, 0);
        run_op(16'd7, 16'd0, 0);
        run_op(16'd8, 16'd0, 0);

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        #1;
        issue(16'd1000, 16'd33);
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        chk("busy_mid_op", 32'(busy), 32'd1);
        start    = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(3 * MBITS + 10);

        // Asynchronous reset mid-operation aborts with no done pulse.
        @(negedge clk);
        #1;
        issue(16'd500, 16'd4);
        repeat (7) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (MBITS + 4) @(negedge clk);
        #1;
        run_op(16'd500, 16'd4, 0);

        // Random sweep with edge-case divisors mixed in.
        for (int i = 0; i < 150; i++) begin
            a   = MBITS'($urandom);
            sel = $urandom_range(0, 11);
            if (sel == 11) a = '0;
            else if (sel == 10) a = MBITS'($urandom_range(0, 20));
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = '0;
                1:       b = 16'd1;
                2:       b = a;
                3:       b = MBITS'($urandom_range(1, 15));
                4:       b = a + 16'd1;
                default: b = MBITS'($urandom);
            endcase
            run_op(a, b, $urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
